// File: rtl/fp_addsub_issuer.sv
// Valid/ready issuer for the FP add/sub stage: LOAD_CYCLES load, SETTLE_CYCLES settle, then wait for add_ready; RESP holds under rsp_ready backpressure.
// `define FP_ADDSUB_ISSUER_TIMEOUT_EN adds a TIMEOUT_CYCLES limit on WAIT that answers with a quiet NaN.
module fp_addsub_issuer #(
  parameter int LOAD_CYCLES    = 1,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        add_en,
  output logic        add_load,
  output logic        add_plus_or_minus,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  input  logic        add_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_timeout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [15:0] LOAD_INIT    = 16'(LOAD_CYCLES - 1);
  localparam logic [15:0] SETTLE_INIT  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_INIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] QNAN         = 32'h7FC0_0000;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic        op_q, op_d, cout_q, cout_d;
`ifdef FP_ADDSUB_ISSUER_TIMEOUT_EN
  logic        to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef FP_ADDSUB_ISSUER_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          cnt_d   = LOAD_INIT;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = SETTLE_INIT;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RUN: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = TIMEOUT_INIT;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT: begin
        // A real result on the limit cycle takes priority over the timeout.
        if (add_ready) begin
          sum_d   = add_sum;
          cout_d  = add_cout;
`ifdef FP_ADDSUB_ISSUER_TIMEOUT_EN
          to_d    = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef FP_ADDSUB_ISSUER_TIMEOUT_EN
        else if (cnt_q == 16'd0) begin
          sum_d   = QNAN;
          cout_d  = 1'b0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end
`endif
        else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 1'b0;
      sum_q   <= 32'd0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef FP_ADDSUB_ISSUER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_q <= 1'b0;
    else     to_q <= to_d;
  end
  assign rsp_timeout = to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // req_ready is gated by rst so it reads 0 while reset is held.
  assign req_ready         = (state_q == S_IDLE) && !rst;
  assign add_load          = (state_q == S_LOAD);
  assign add_en            = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_WAIT);
  assign add_plus_or_minus = op_q;
  assign add_a             = a_q;
  assign add_b             = b_q;
  assign add_cin           = 1'b0;
  assign rsp_valid         = (state_q == S_RESP);
  assign rsp_sum           = sum_q;
  assign rsp_cout          = cout_q;

endmodule
